// File: rtl/bram_image_loader_pkg.sv
// Shared definitions for the image BRAM fill path: channel codes understood by the
// BRAM controller, plus the R->G->B channel stepping helper.
package bram_image_loader_pkg;

  localparam logic [1:0] CH_RED   = 2'b01;
  localparam logic [1:0] CH_GREEN = 2'b10;
  localparam logic [1:0] CH_BLUE  = 2'b11;

  function automatic logic [1:0] next_channel(input logic [1:0] ch);
    unique case (ch)
      CH_RED:   next_channel = CH_GREEN;
      CH_GREEN: next_channel = CH_BLUE;
      default:  next_channel = CH_RED;
    endcase
  endfunction

endpackage

// File: rtl/bram_image_loader.sv
// Byte-stream to three-channel image BRAM fill stage; interleaved R,G,B bytes in, registered writes out.
// Optional frame checksum output enabled by defining LOADER_CHECKSUM_EN.
module bram_image_loader
  import bram_image_loader_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int NUM_PIXELS = 76800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [1:0]        bram_channel,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_data,
  output logic              busy,
  output logic              done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        ch_q;
  logic [DATA_W-1:0] data_q;

  logic accept;
  logic last_byte;

  assign in_ready  = (state_q == S_LOAD);
  assign accept    = in_valid & in_ready;
  assign last_byte = (ptr_q == CH_BLUE) && (cnt_q == LAST_PIX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          ptr_d   = CH_RED;
        end
      end
      S_LOAD: begin
        if (accept) begin
          ptr_d = next_channel(ptr_q);
          // Counter stops on the final pixel so it can never run past the frame.
          if (last_byte) begin
            state_d = S_DONE;
          end else if (ptr_q == CH_BLUE) begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= CH_RED;
      we_q    <= 1'b0;
      addr_q  <= '0;
      ch_q    <= CH_RED;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= accept;
      // Address/channel/data hold their last written values between writes.
      if (accept) begin
        addr_q <= cnt_q;
        ch_q   <= ptr_q;
        data_q <= in_data;
      end
    end
  end

  assign bram_addr    = addr_q;
  assign bram_channel = ch_q;
  assign bram_we      = we_q;
  assign bram_data    = data_q;
  assign busy         = (state_q == S_LOAD);
  assign done         = (state_q == S_DONE);

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q == S_IDLE && start)) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + 16'(in_data);
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_bram_image_loader.sv
// Self-checking bench for bram_image_loader with a 4-pixel frame; expected BRAM writes
// are queued when bytes are driven and popped when the loader issues them.
module tb_bram_image_loader;
  import bram_image_loader_pkg::*;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int NP     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] bram_addr;
  logic [1:0]        bram_channel;
  logic              bram_we;
  logic [DATA_W-1:0] bram_data;
  logic              busy;
  logic              done;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  always #5 clk = ~clk;

  bram_image_loader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_PIXELS(NP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bram_addr   (bram_addr),
    .bram_channel(bram_channel),
    .bram_we     (bram_we),
    .bram_data   (bram_data),
    .busy        (busy),
    .done        (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  typedef struct packed {
    logic [7:0]        data;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        ch;
  } vec_t;

  vec_t vec_tbl[12];
  vec_t exp_q[$];
  int   n_cmp;
  int   n_fail;
  int   done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Mid-cycle sampling of the write port against the scoreboard.
  task automatic sample();
    if (bram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d ch=%b data=%0h, expected no write",
                 bram_addr, bram_channel, bram_data);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        $display("write addr=%0d ch=%b data=%02h (expected %0d/%b/%02h)",
                 bram_addr, bram_channel, bram_data, e.addr, e.ch, e.data);
        chk("wr_addr", 32'(bram_addr), 32'(e.addr));
        chk("wr_ch",   32'(bram_channel), 32'(e.ch));
        chk("wr_data", 32'(bram_data), 32'(e.data));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_with_we", 32'(bram_we), 1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    vec_t e;
    in_valid = 1'b1;
    in_data  = d;
    chk("in_ready", 32'(in_ready), 1);
    e      = vec_tbl[idx];
    e.data = d;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) tick();
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  task automatic check_done_cycle(input logic [15:0] exp_sum);
    chk("done_pulse", 32'(done), 1);
    chk("done_we", 32'(bram_we), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_ready", 32'(in_ready), 0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(exp_sum));
`else
    if (exp_sum == 16'hFFFF) $display("note: checksum disabled");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_tbl[0]  = '{8'h01, 17'd0, CH_RED};
    vec_tbl[1]  = '{8'h02, 17'd0, CH_GREEN};
    vec_tbl[2]  = '{8'h03, 17'd0, CH_BLUE};
    vec_tbl[3]  = '{8'h04, 17'd1, CH_RED};
    vec_tbl[4]  = '{8'h05, 17'd1, CH_GREEN};
    vec_tbl[5]  = '{8'h06, 17'd1, CH_BLUE};
    vec_tbl[6]  = '{8'h07, 17'd2, CH_RED};
    vec_tbl[7]  = '{8'h08, 17'd2, CH_GREEN};
    vec_tbl[8]  = '{8'h09, 17'd2, CH_BLUE};
    vec_tbl[9]  = '{8'h0A, 17'd3, CH_RED};
    vec_tbl[10] = '{8'h0B, 17'd3, CH_GREEN};
    vec_tbl[11] = '{8'h0C, 17'd3, CH_BLUE};

    n_cmp = 0; n_fail = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset
    repeat (3) tick();
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_addr", 32'(bram_addr), 0);
    chk("rst_ch", 32'(bram_channel), 32'(CH_RED));
    chk("rst_we", 32'(bram_we), 0);
    chk("rst_data", 32'(bram_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    chk("idle_ready", 32'(in_ready), 0);
    tick();
    chk("idle_no_we", 32'(bram_we), 0);
    in_valid = 1'b0;
    tick();

    // Full frame, back to back
    done_cnt = 0;
    do_start();
    chk("load_busy", 32'(busy), 1);
    for (int i = 0; i < 12; i++) send(i, vec_tbl[i].data);
    check_done_cycle(16'h004E);
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    chk("post_done", 32'(done), 0);
    chk("post_ready", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0;
    drain();
`ifdef LOADER_CHECKSUM_EN
    chk("checksum_hold", 32'(checksum), 32'h004E);
`endif
    chk("frame_done_cnt", 32'(done_cnt), 1);

    // Gaps in in_valid
    done_cnt = 0;
    do_start();
    for (int i = 0; i < 12; i++) begin
      send(i, vec_tbl[i].data);
      if (i < 11 && (i % 2) == 0) begin
        tick();
        if (i == 0) begin
          chk("gap_no_we", 32'(bram_we), 0);
          chk("gap_addr_hold", 32'(bram_addr), 0);
          chk("gap_ch_hold", 32'(bram_channel), 32'(CH_RED));
        end
        tick();
      end
    end
    check_done_cycle(16'h004E);
    tick();
    drain();
    chk("gap_done_cnt", 32'(done_cnt), 1);

    // Start pulse during LOAD is ignored
    done_cnt = 0;
    do_start();
    for (int i = 0; i < 5; i++) send(i, vec_tbl[i].data);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start_busy", 32'(busy), 1);
    for (int i = 5; i < 12; i++) send(i, vec_tbl[i].data);
    check_done_cycle(16'h004E);
    tick();
    drain();
    chk("ign_done_cnt", 32'(done_cnt), 1);

    // Reset in the middle of a load
    done_cnt = 0;
    do_start();
    for (int i = 0; i < 5; i++) send(i, vec_tbl[i].data);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_we", 32'(bram_we), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(bram_addr), 0);
    chk("mid_rst_ch", 32'(bram_channel), 32'(CH_RED));
    drain();
    do_start();
    for (int i = 0; i < 12; i++) send(i, vec_tbl[i].data);
    check_done_cycle(16'h004E);
    tick();
    drain();
    chk("mid_rst_done_cnt", 32'(done_cnt), 1);

    // Second frame of 0xFF bytes; checksum restarts from zero
    done_cnt = 0;
    do_start();
    for (int i = 0; i < 12; i++) send(i, 8'hFF);
    check_done_cycle(16'h0BF4);
    tick();
    drain();
    chk("ff_done_cnt", 32'(done_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
